soft_core_cpu_output_capture: RTL
=================================

# soft_core_cpu_output_capture

Parametrised capture buffer between the soft-core CPU and the seven-segment display wrapper. After a CPU start pulse it records the first DEPTH values the CPU emits on DOUT strobes into display slots, then holds them. It extends the fixed two-digit capture with configurable width and depth, an optional circular "keep latest" mode, re-arm on a new CPU start, a read port and status flags.

## Interface
Parameters:
- WIDTH, 8, bits per captured CPU output value.
- DEPTH, 4, number of capture slots (≥2).
- WRAP, 0, 0 = stop when full; 1 = circular, keep the latest DEPTH values.

Ports:
- CLK  in  1  single system clock; all logic is on the rising edge.
- CLR  in  1  synchronous, active-high reset.
- CPU_EN_pulse  in  1  one-cycle CPU start strobe; arms or re-arms capture.
- DOUT_pulse  in  1  one-cycle CPU output-valid strobe.
- CPU_OUTPUT_VAL  in  WIDTH  CPU output value, sampled when DOUT_pulse=1.
- NUM_BUFF  out  WIDTH*DEPTH  slot k at bits [k*WIDTH +: WIDTH]; registered.
- RD_IDX  in  $clog2(DEPTH)  read-port slot select.
- RD_DATA  out  WIDTH  combinational; slot RD_IDX, or 0 if RD_IDX ≥ DEPTH.
- COUNT  out  $clog2(DEPTH+1)  number of slots filled since the last arm; registered.
- ARMED  out  1  1 in CAPT state.
- FULL  out  1  COUNT == DEPTH.
- OVF  out  1  sticky overflow flag (see Configuration).

## Operation
- States: IDLE, CAPT, DONE. Reset and power-up go to IDLE with NUM_BUFF=0, COUNT=0, OVF=0, ARMED=0, FULL=0.
- IDLE: DOUT_pulse is ignored. CPU_EN_pulse moves to CAPT.
- Arm action: on every CPU_EN_pulse in any state, clear all slots, set COUNT=0 and OVF=0, and enter CAPT.
- CAPT, DOUT_pulse with COUNT<DEPTH: write the value to slot DEPTH-1-COUNT and increment COUNT. The first value lands in the top (leftmost) slot.
  - WRAP=0: the write that makes COUNT=DEPTH moves the block to DONE.
  - WRAP=1: the block stays in CAPT when full.
- CAPT, WRAP=1, FULL, DOUT_pulse: shift slot k ← slot k-1 for k=DEPTH-1..1, write slot 0 ← new value, and set OVF. COUNT stays at DEPTH.
- DONE: slots are frozen. DOUT_pulse sets OVF only. CPU_EN_pulse re-arms.
- Priority each cycle: CLR > CPU_EN_pulse > DOUT_pulse. When CPU_EN_pulse and DOUT_pulse arrive in the same cycle, the block arms and drops the DOUT value.
- CLR mid-capture discards all contents immediately and returns to IDLE.

## Timing
- Sample on edge N (DOUT_pulse=1) → NUM_BUFF, COUNT, FULL and state are updated after edge N and visible in cycle N+1.
- RD_DATA follows RD_IDX and NUM_BUFF with zero cycles of latency.
- Back-to-back DOUT_pulse on consecutive cycles captures every value. No stall and no handshake back to the CPU.
- ARMED, FULL and OVF are registered or decoded from registered state. They are glitch-free relative to CLK.

## Configuration
- Macro OUTPUT_CAPTURE_OVF_EN.
- Defined: OVF behaves as described and stays set until CLR or a re-arm.
- Undefined: the OVF logic is not compiled. The OVF port remains and is tied to 0. All other behaviour is identical.

## Test plan
- WIDTH=8, DEPTH=2, WRAP=0: CLR, then EN, then DOUT with 0x12 followed by DOUT with 0x34 → NUM_BUFF=0x1234, COUNT=2, FULL=1, DONE. A third DOUT with 0x56 leaves NUM_BUFF unchanged and sets OVF=1 (macro defined).
- IDLE: DOUT with 0xAA before any EN → NUM_BUFF=0 and COUNT=0. After EN and DOUT with 0x01, slot DEPTH-1=0x01 and COUNT=1.
- DEPTH=4, WRAP=1: after EN, DOUT values 1,2,3,4,5,6 on consecutive cycles → NUM_BUFF={3,4,5,6} (slot3..slot0), COUNT=4, OVF=1, ARMED=1.
- Same cycle EN and DOUT with 0x77 while in DONE → all slots=0, COUNT=0, OVF=0, CAPT, and 0x77 is not stored.
- CLR asserted in CAPT with COUNT=2 → the next cycle shows IDLE with NUM_BUFF=0, COUNT=0, ARMED=0. RD_IDX=DEPTH gives RD_DATA=0.
- Macro undefined: rerun the wrap-mode scenario → OVF stays 0 throughout and the data results match.

Source files
------------

// File: rtl/soft_core_cpu_output_capture.sv
// Capture buffer between the soft-core CPU and the seven-segment display wrapper.
// Optional sticky overflow flag is compiled in when OUTPUT_CAPTURE_OVF_EN is defined.
module soft_core_cpu_output_capture #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int WRAP  = 0
) (
  input  logic                       CLK,
  input  logic                       CLR,
  input  logic                       CPU_EN_pulse,
  input  logic                       DOUT_pulse,
  input  logic [WIDTH-1:0]           CPU_OUTPUT_VAL,
  output logic [WIDTH*DEPTH-1:0]     NUM_BUFF,
  input  logic [$clog2(DEPTH)-1:0]   RD_IDX,
  output logic [WIDTH-1:0]           RD_DATA,
  output logic [$clog2(DEPTH+1)-1:0] COUNT,
  output logic                       ARMED,
  output logic                       FULL,
  output logic                       OVF
);

  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CAPT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_reg, state_next;
  logic [CW-1:0]    count_reg, count_next;
  logic [WIDTH-1:0] slot_reg  [DEPTH];
  logic [WIDTH-1:0] slot_next [DEPTH];
  logic             full_w;
  logic             capt_write;
  logic             wrap_shift;

  assign full_w     = (count_reg == CW'(DEPTH));
  assign capt_write = DOUT_pulse && !CPU_EN_pulse && (state_reg == S_CAPT) && !full_w;
  assign wrap_shift = DOUT_pulse && !CPU_EN_pulse && (state_reg == S_CAPT) && full_w
                      && (WRAP != 0);

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    for (int k = 0; k < DEPTH; k++) begin
      slot_next[k] = slot_reg[k];
    end

    if (CPU_EN_pulse) begin
      // Arming always wins over a coincident DOUT strobe, whose value is dropped.
      state_next = S_CAPT;
      count_next = '0;
      for (int k = 0; k < DEPTH; k++) begin
        slot_next[k] = '0;
      end
    end else if (capt_write) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (k == DEPTH - 1 - int'(count_reg)) begin
          slot_next[k] = CPU_OUTPUT_VAL;
        end
      end
      count_next = count_reg + CW'(1);
      if (WRAP == 0 && count_reg == CW'(DEPTH - 1)) begin
        state_next = S_DONE;
      end
    end else if (wrap_shift) begin
      // Oldest value falls off the top slot; newest enters at slot 0.
      for (int k = DEPTH - 1; k > 0; k--) begin
        slot_next[k] = slot_reg[k-1];
      end
      slot_next[0] = CPU_OUTPUT_VAL;
    end
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_reg <= S_IDLE;
      count_reg <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        slot_reg[k] <= '0;
      end
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      for (int k = 0; k < DEPTH; k++) begin
        slot_reg[k] <= slot_next[k];
      end
    end
  end

`ifdef OUTPUT_CAPTURE_OVF_EN
  logic ovf_reg, ovf_next;

  always_comb begin
    ovf_next = ovf_reg;
    if (CPU_EN_pulse) begin
      ovf_next = 1'b0;
    end else if (DOUT_pulse && (wrap_shift || state_reg == S_DONE)) begin
      ovf_next = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      ovf_reg <= 1'b0;
    end else begin
      ovf_reg <= ovf_next;
    end
  end

  assign OVF = ovf_reg;
`else
  assign OVF = 1'b0;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_pack
      assign NUM_BUFF[gi*WIDTH +: WIDTH] = slot_reg[gi];
    end
  endgenerate

  // Loop-based select keeps out-of-range indices (non power-of-two DEPTH) at zero.
  always_comb begin
    RD_DATA = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (int'(RD_IDX) == k) begin
        RD_DATA = slot_reg[k];
      end
    end
  end

  assign COUNT = count_reg;
  assign ARMED = (state_reg == S_CAPT);
  assign FULL  = full_w;

endmodule
